// File: rtl/symbol_tally.sv
// Scorekeeper: tallies target symbols in the game period and judges the player's count after the answer period.
// Every output is a flop; judgement is registered one edge after postPeriodB. There is no backpressure and every input is sampled each cycle.
module symbol_tally #(
   parameter int CW        = 7,
   parameter int LW        = 5,
   parameter int MAX_LEVEL = 16,
   parameter int TOLERANCE = 0
) (
   input  logic          Clk100M,
   input  logic          reset,
   input  logic          symStrobe,
   input  logic          specialCount,
   input  logic          prelimPeriodB,
   input  logic          gamePeriodB,
   input  logic          answerPeriodB,
   input  logic          postPeriodB,
   input  logic [CW-1:0] userCount,
   output logic [CW-1:0] gameCount,
   output logic [CW-1:0] countDifference,
   output logic          loss,
   output logic          levelUp,
   output logic [LW-1:0] level,
   output logic          judged
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRELIM = 3'd1,
      GAME   = 3'd2,
      ANSWER = 3'd3,
      JUDGE  = 3'd4,
      POST   = 3'd5,
      LOST   = 3'd6
   } state_t;

   localparam logic [CW-1:0] countMax  = {CW{1'b1}};
   localparam logic [LW-1:0] levelMax  = LW'(MAX_LEVEL);
   localparam logic [CW-1:0] tolerance = CW'(TOLERANCE);

   state_t        state;
   state_t        nextState;
   logic [CW-1:0] absDiff;
   logic          judgePass;

   logic [CW-1:0] gameCountNext;
   logic [CW-1:0] countDifferenceNext;
   logic          lossNext;
   logic          levelUpNext;
   logic [LW-1:0] levelNext;
   logic          judgedNext;

   // Subtract the smaller from the larger so the magnitude never wraps.
   always_comb begin
      if (userCount >= gameCount) begin
         absDiff = userCount - gameCount;
      end else begin
         absDiff = gameCount - userCount;
      end
      judgePass = (absDiff <= tolerance);
   end

   always_ff @(posedge Clk100M or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, POST: if (prelimPeriodB) nextState = PRELIM;
         PRELIM:     if (gamePeriodB)   nextState = GAME;
         GAME:       if (answerPeriodB) nextState = ANSWER;
         ANSWER:     if (postPeriodB)   nextState = JUDGE;
         JUDGE:      nextState = judgePass ? POST : LOST;
         LOST:       nextState = LOST;
         default:    nextState = IDLE;
      endcase
   end

   always_comb begin
      gameCountNext       = gameCount;
      countDifferenceNext = countDifference;
      lossNext            = loss;
      levelUpNext         = 1'b0;
      levelNext           = level;
      judgedNext          = judged;
      case (state)
         IDLE, POST: begin
            if (prelimPeriodB) begin
               gameCountNext       = '0;
               countDifferenceNext = '0;
               judgedNext          = 1'b0;
            end
         end
         GAME: begin
            if (symStrobe && specialCount && (gameCount != countMax)) begin
               gameCountNext = gameCount + CW'(1);
            end
         end
         JUDGE: begin
            countDifferenceNext = absDiff;
            judgedNext          = 1'b1;
            if (!judgePass) begin
               lossNext = 1'b1;
            end else if (level < levelMax) begin
               levelNext   = level + LW'(1);
               levelUpNext = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clk100M or posedge reset) begin
      if (reset) begin
         gameCount       <= '0;
         countDifference <= '0;
         loss            <= 1'b0;
         levelUp         <= 1'b0;
         level           <= LW'(1);
         judged          <= 1'b0;
      end else begin
         gameCount       <= gameCountNext;
         countDifference <= countDifferenceNext;
         loss            <= lossNext;
         levelUp         <= levelUpNext;
         level           <= levelNext;
         judged          <= judgedNext;
      end
   end

endmodule

// File: doc/symbol_tally.md
# symbol_tally

Scorekeeper on the consuming end of the symbol generator's output. It counts the target symbols the generator flags during the game period, then checks the player's count against that tally at the end of the answer period. From that check it reports the score difference, sets loss, and advances the level. It drives `gameCount`, `countDifference`, `loss` and `level` toward the display and level logic.

## Interface
- `CW`, 7: width of every count (`gameCount`, `userCount`, `countDifference`).
- `LW`, 5: level width.
- `MAX_LEVEL`, 16: highest level; `level` never increments past it.
- `TOLERANCE`, 0: largest difference still scored as a pass.

- `Clk100M` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `symStrobe` in 1: one-cycle pulse, one per generated symbol.
- `specialCount` in 1: qualifies `symStrobe`; 1 means the current symbol is a target.
- `prelimPeriodB` in 1: one-cycle pulse marking the start of the prelim period.
- `gamePeriodB` in 1: one-cycle pulse marking the start of the game period.
- `answerPeriodB` in 1: one-cycle pulse marking the start of the answer period.
- `postPeriodB` in 1: one-cycle pulse marking the start of the post period.
- `userCount` in CW: player's count from the up/down button counter.
- `gameCount` out CW: registered tally of target symbols.
- `countDifference` out CW: registered |userCount − gameCount|, i.e. the score.
- `loss` out 1: sticky level; set when difference > TOLERANCE.
- `levelUp` out 1: one-cycle pulse on a passing judgement.
- `level` out LW: current level, starting at 1.
- `judged` out 1: high from judgement until the next prelim start.

## Operation
- States:
  - IDLE
  - PRELIM
  - GAME
  - ANSWER
  - JUDGE
  - POST
  - LOST
- Reset state is IDLE. Reset values of the outputs:
  - `gameCount`=0, `countDifference`=0, `loss`=0, `levelUp`=0, `level`=1, `judged`=0.
- IDLE/POST → PRELIM on `prelimPeriodB`. On entry, clear `gameCount`, `countDifference` and `judged`.
- PRELIM → GAME on `gamePeriodB`.
- GAME: on each edge where `symStrobe`&&`specialCount`, increment `gameCount`.
  - The count saturates at 2^CW−1; no wrap.
  - GAME → ANSWER on `answerPeriodB`.
- ANSWER: `gameCount` is frozen and strobes are ignored. ANSWER → JUDGE on `postPeriodB`.
- JUDGE lasts exactly one cycle:
  - Compute `countDifference` = |userCount − gameCount| as an unsigned magnitude, with no sign bit and no wrap.
  - Set `judged`=1.
  - Fail (difference > TOLERANCE): set `loss`=1 and go to LOST.
  - Pass: if `level` < MAX_LEVEL, set `level`+=1 and pulse `levelUp`; otherwise leave `level` unchanged and do not pulse `levelUp`. Go to POST.
- LOST: absorbing state. Every input is ignored and outputs hold until `reset`.
- A period pulse that does not match the current state's exit condition is ignored, with no state change. This covers out-of-order and repeated pulses.
- A `symStrobe` is ignored outside GAME.

## Timing
- Every output is a flop output; no combinational path runs from input to output.
- Strobe in GAME at edge k: `gameCount` updated after edge k.
- A qualified strobe in the same cycle as `answerPeriodB` is counted; that edge takes GAME → ANSWER.
- Judgement sequence:
  - `postPeriodB` sampled at edge k: state becomes JUDGE.
  - Edge k+1: `userCount` is sampled, and `countDifference`, `loss`, `judged`, `level` and `levelUp` are registered.
  - `levelUp` is high from edge k+1 to edge k+2 only.
- Any strobe or pulse arriving during JUDGE is ignored.
- `reset` asserted mid-operation, including in JUDGE or LOST: outputs take their reset values asynchronously, without waiting for a clock edge. Resumption starts from IDLE on the first edge after `reset` deasserts.

## Test plan
- Reset, then walk the periods:
  - Stimulus: prelim, game, 5 qualified strobes plus 3 unqualified strobes, answer, then post with `userCount`=5.
  - Response: `gameCount`=5, `countDifference`=0, `loss`=0, `level`=2, a single-cycle `levelUp` at edge k+1.
- Same sequence with `userCount`=2 → `countDifference`=3, `loss`=1, state LOST. Then send a further prelim pulse → no change to any output.
- Set `userCount`=9 against `gameCount`=5 and, separately, `userCount`=1 against `gameCount`=5 → `countDifference`=4 in both cases, with no wrap to 124.
- Send 130 qualified strobes → `gameCount`=127 (saturated). Send a strobe together with `answerPeriodB` → it is counted.
- Walk 15 passing rounds to reach `level`=16 → a further pass leaves `level`=16 with no `levelUp`. Also send `answerPeriodB` while in PRELIM → it is ignored.
- Assert `reset` in the JUDGE cycle → all outputs take their reset values before the next edge, and the state is IDLE.
